// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter:
// data width, opcode encodings and the output-register state type.
package alu_pkg;

    // Datapath width of the shared ALU
    localparam int ALU_W = 32;

    // Increment/decrement step, sized to the datapath
    localparam logic [ALU_W-1:0] ALU_ONE = 1;

    // Opcode encodings understood by the ALU
    localparam logic [2:0] OP_PASSA = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_INC   = 3'b101;
    localparam logic [2:0] OP_DEC   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Output register occupancy: EMPTY holds nothing, FULL holds one result
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/ALU.sv
// Purely combinational 32-bit, 8-function ALU. Arithmetic wraps modulo
// 2^ALU_W and no carry or overflow information is produced.
module ALU
    import alu_pkg::*;
(
    input  logic [2:0]       Op_code,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    output logic [ALU_W-1:0] Y
);

    // Select the function result for the current opcode
    always_comb begin
        Y = A;
        case (Op_code)
            OP_PASSA: Y = A;
            OP_ADD:   Y = A + B;
            OP_SUB:   Y = A - B;
            OP_AND:   Y = A & B;
            OP_OR:    Y = A | B;
            OP_INC:   Y = A + ALU_ONE;
            OP_DEC:   Y = A - ALU_ONE;
            OP_PASSB: Y = B;
            default:  Y = A;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters. A round-robin pointer
// breaks ties, the winning operation is computed in the same cycle and
// captured in a one-deep output register tagged with the requester id.
// Per-requester grant counters wrap silently and exist for debug only.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int RR_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [ALU_W-1:0] rsp_y,

    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_nextState;

    logic             r_rr;
    logic             r_rspId;
    logic [ALU_W-1:0] r_rspY;
    logic [CNT_W-1:0] r_grantCnt0;
    logic [CNT_W-1:0] r_grantCnt1;

    logic             w_canAccept;
    logic             w_anyValid;
    logic             w_grantId;
    logic             w_accept;

    logic [2:0]       w_aluOp;
    logic [ALU_W-1:0] w_aluA;
    logic [ALU_W-1:0] w_aluB;
    logic [ALU_W-1:0] w_aluY;

    // Output-register state: a held result is dropped immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next occupancy: fill on accept, empty on a drain with nothing new
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_nextState = FULL;
                end
            end
            FULL: begin
                if (w_accept) begin
                    w_nextState = FULL;
                end else if (rsp_ready) begin
                    w_nextState = EMPTY;
                end
            end
            default: w_nextState = EMPTY;
        endcase
    end

    // Room exists when empty or when the held result leaves this cycle
    always_comb begin
        rsp_valid   = (r_state == FULL);
        w_canAccept = (r_state == EMPTY) || rsp_ready;
    end

    // Round-robin choice: a lone requester wins, a tie goes to r_rr;
    // readies are forced low while reset is asserted
    always_comb begin
        w_anyValid = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            w_grantId = r_rr;
        end else begin
            w_grantId = req1_valid;
        end
        w_accept   = w_canAccept && w_anyValid && !rst;
        req0_ready = w_accept && !w_grantId;
        req1_ready = w_accept &&  w_grantId;
    end

    // Steer the granted requester's operation into the shared ALU
    always_comb begin
        if (w_grantId) begin
            w_aluOp = req1_op;
            w_aluA  = req1_a;
            w_aluB  = req1_b;
        end else begin
            w_aluOp = req0_op;
            w_aluA  = req0_a;
            w_aluB  = req0_b;
        end
    end

    ALU uAlu (
        .Op_code (w_aluOp),
        .A       (w_aluA),
        .B       (w_aluB),
        .Y       (w_aluY)
    );

    // Capture result and id on accept; otherwise they hold for the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspY  <= '0;
            r_rspId <= 1'b0;
        end else if (w_accept) begin
            r_rspY  <= w_aluY;
            r_rspId <= w_grantId;
        end
    end

    // Priority passes to the requester that did not win; idle cycles keep it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= RR_INIT[0];
        end else if (w_accept) begin
            r_rr <= !w_grantId;
        end
    end

    // Count accepted operations per requester, wrapping at full scale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grantCnt0 <= '0;
            r_grantCnt1 <= '0;
        end else if (w_accept) begin
            if (w_grantId) begin
                r_grantCnt1 <= r_grantCnt1 + CNT_ONE;
            end else begin
                r_grantCnt0 <= r_grantCnt0 + CNT_ONE;
            end
        end
    end

    assign rsp_y      = r_rspY;
    assign rsp_id     = r_rspId;
    assign grant_cnt0 = r_grantCnt0;
    assign grant_cnt1 = r_grantCnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbiter.
module tb_alu_arbiter;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic [2:0]          req0_op, req1_op;
    logic [31:0]         req0_a, req0_b, req1_a, req1_b;
    logic                rsp_valid, rsp_ready, rsp_id;
    logic [31:0]         rsp_y;
    logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model: one-deep result slot, priority holder, counters
    bit          mValid;
    bit          mId;
    logic [31:0] mY;
    int          mCnt [2];
    bit          mRr;
    bit          lastAcc;
    bit          lastGrant;

    alu_arbiter #(.CNT_W(TB_CNT_W), .RR_INIT(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0:    r = a;
            3'd1:    r = a + b;
            3'd2:    r = a - b;
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            3'd5:    r = a + 32'd1;
            3'd6:    r = a - 32'd1;
            default: r = b;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid  = 1'b0;
        mId     = 1'b0;
        mY      = 32'd0;
        mCnt[0] = 0;
        mCnt[1] = 0;
        mRr     = 1'b0;
    endtask

    task automatic checkOutput();
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, mValid});
        if (mValid) begin
            check("rsp_id", {31'd0, rsp_id}, {31'd0, mId});
            check("rsp_y", rsp_y, mY);
        end
        check("grant_cnt0", {28'd0, grant_cnt0}, 32'(mCnt[0]));
        check("grant_cnt1", {28'd0, grant_cnt1}, 32'(mCnt[1]));
    endtask

    // Drive one cycle of stimulus starting just after a rising edge,
    // check readies mid-cycle, then outputs just after the next edge
    task automatic applyStimulus(
        input bit v0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
        input bit v1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
        input bit rr
    );
        bit canAcc, acc, g;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        #1;
        canAcc = !mValid || rr;
        g      = (v0 && v1) ? mRr : v1;
        acc    = canAcc && (v0 || v1);
        check("req0_ready", {31'd0, req0_ready}, {31'd0, acc && !g});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, acc && g});
        @(posedge clk);
        if (acc) begin
            mY      = g ? aluRef(o1, a1, b1) : aluRef(o0, a0, b0);
            mId     = g;
            mCnt[g] = (mCnt[g] + 1) % (2 ** TB_CNT_W);
            mRr     = !g;
            mValid  = 1'b1;
        end else if (rr) begin
            mValid = 1'b0;
        end
        lastAcc   = acc;
        lastGrant = g;
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // Directed scenarios, then randomized traffic
    initial begin
        logic [31:0] expY [4];
        logic [31:0] opY  [8];
        bit          p0, p1, v0, v1, rr;
        logic [2:0]  o0, o1;
        logic [31:0] a0, b0, a1, b1;

        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'd5; req0_b = 32'd7;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready  = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        check("reset_ready0", {31'd0, req0_ready}, 32'd0);
        check("reset_ready1", {31'd0, req1_ready}, 32'd0);
        resetDut();
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_rsp_y", rsp_y, 32'd0);
        check("reset_cnt0", {28'd0, grant_cnt0}, 32'd0);
        check("reset_cnt1", {28'd0, grant_cnt1}, 32'd0);

        // Single add from requester 0
        applyStimulus(1'b1, 3'b001, 32'd5, 32'd7, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("first_y", rsp_y, 32'd12);
        check("first_id", {31'd0, rsp_id}, 32'd0);
        check("first_cnt0", {28'd0, grant_cnt0}, 32'd1);

        // Reset while FULL with requester 0 still valid
        req0_valid = 1'b1;
        rsp_ready  = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("async_cnt0", {28'd0, grant_cnt0}, 32'd0);
        check("async_ready0", {31'd0, req0_ready}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("inrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("inrst_cnt0", {28'd0, grant_cnt0}, 32'd0);
        check("inrst_ready0", {31'd0, req0_ready}, 32'd0);
        rst = 1'b0;
        modelReset();

        // Both requesters valid: strict alternation from the reset priority
        expY = '{32'd7, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'b010, 32'd10, 32'd3, 1'b1, 3'b110, 32'd0, 32'd0, 1'b1);
            check("alt_id", {31'd0, rsp_id}, 32'(i % 2));
            check("alt_y", rsp_y, expY[i]);
        end
        check("alt_cnt0", {28'd0, grant_cnt0}, 32'd2);
        check("alt_cnt1", {28'd0, grant_cnt1}, 32'd2);

        // Backpressure: result held, both readies low
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'b010, 32'd10, 32'd3, 1'b1, 3'b110, 32'd0, 32'd0, 1'b0);
            check("bp_id", {31'd0, rsp_id}, 32'd1);
            check("bp_y", rsp_y, 32'hFFFF_FFFF);
        end
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        check("b2b_y", rsp_y, 32'hF000_F000);

        // Every opcode from requester 1
        opY = '{32'd8, 32'd11, 32'd5, 32'd0, 32'd11, 32'd9, 32'd7, 32'd3};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'(i), 32'd8, 32'd3, 1'b1);
            check("opcode_y", rsp_y, opY[i]);
        end

        // Counter wrap: 17 accepts through a 4-bit counter
        resetDut();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 3'b001, $urandom, $urandom, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        end
        check("wrap_cnt0", {28'd0, grant_cnt0}, 32'd1);

        // Randomized traffic obeying the hold-while-stalled rule
        p0 = 1'b0; p1 = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        o0 = 3'd0; o1 = 3'd0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!p0) begin
                v0 = ($urandom_range(0, 3) != 0);
                o0 = 3'($urandom);
                a0 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                b0 = $urandom;
            end
            if (!p1) begin
                v1 = ($urandom_range(0, 3) != 0);
                o1 = 3'($urandom);
                a1 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                b1 = $urandom;
            end
            rr = ($urandom_range(0, 9) < 7);
            applyStimulus(v0, o0, a0, b0, v1, o1, a1, b1, rr);
            p0 = v0 && !(lastAcc && !lastGrant);
            p1 = v1 && !(lastAcc && lastGrant);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's 32-bit, 8-function ALU (module `ALU`, ports `Op_code`/`A`/`B`/`Y`) between two independent requesters. Each requester presents an opcode and two operands with a valid/ready handshake. A round-robin arbiter admits at most one operation per cycle. The result is captured in a one-deep output register tagged with the winning requester's id, and per-requester grant counters are kept for debug.

## Interface
- `CNT_W`, default 16: width of each grant counter.
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: requester has an operation pending.
- `req0_ready`, `req1_ready` out 1: operation accepted this cycle when valid & ready.
- `req0_op`, `req1_op` in 3: ALU opcode. Encodings 000 A, 001 A+B, 010 A−B, 011 A&B, 100 A|B, 101 A+1, 110 A−1, 111 B.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 32: operands.
- `rsp_valid` out 1: the output register holds a result.
- `rsp_ready` in 1: the consumer takes the result when valid & ready.
- `rsp_id` out 1: requester that issued the held result.
- `rsp_y` out 32: held result.
- `grant_cnt0`, `grant_cnt1` out CNT_W: number of accepted operations per requester.

## Operation
- Output-register state machine has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `rsp_valid & rsp_ready` with no new accept.
  - FULL → FULL on drain and accept in the same cycle (back-to-back).
  - FULL with no drain: hold. No accept can occur.
- `can_accept = (state==EMPTY) | rsp_ready`.
- Arbitration with one priority pointer `rr`:
  - Only req0 valid → grant 0. Only req1 valid → grant 1.
  - Both valid → grant `rr`.
  - None valid → no grant.
  - `reqN_ready = can_accept & grant==N`. The losing or idle requester sees ready low.
- On accept:
  - The mux drives the ALU with the granted op/a/b.
  - The ALU `Y` loads into `rsp_y`, the granted index into `rsp_id`, and the granted counter increments.
  - `rr` moves to the non-granted requester. `rr` does not change when no accept occurs.
- ALU arithmetic is modulo 2^32. There are no carry or overflow flags. A−1 with A=0 gives FFFF_FFFF.
- Grant counters wrap from 2^CNT_W−1 to 0 silently.
- `rsp_y` and `rsp_id` hold stable while `rsp_valid & !rsp_ready`.
- Requester rules:
  - A requester holds op/a/b stable while valid & !ready.
  - A requester must not derive valid from ready.
  - Ready may depend combinationally on both valids and on `rsp_ready`.
- Reset, including mid-transaction:
  - state → EMPTY, `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, both counters=0, `rr`=RR_INIT.
  - A held result is discarded. Both `reqN_ready` outputs are 0 while `rst` is high.

## Timing
- Accept on edge N → `rsp_valid`=1 with result after edge N (latency 1 cycle).
- Sustained throughput is one op per cycle when `rsp_ready` stays high. Both requesters continuously valid alternate 0,1,0,1 (starting at RR_INIT).
- `rsp_ready` low with FULL → both readies low in the same cycle (combinational backpressure).
- Reset is asynchronous assert. Deassertion is expected synchronous to `clk` externally.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_PASSA`…`OP_PASSB` (3'b000–3'b111);
  - data width constant `ALU_W`=32;
  - state typedef {EMPTY, FULL}.
- One sub-module: the existing `ALU`, instantiated once and fed by a combinational 2:1 mux on the grant.
- The arbiter, output register, and counters live in `alu_arbiter` itself.

## Test plan
- Reset → all outputs 0, `rr`=0. Then req0: op=001, A=5, B=7, rsp_ready=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_y`=12, `grant_cnt0`=1.
- Both valid for 4 cycles, rsp_ready=1:
  - req0 op=010 A=10 B=3;
  - req1 op=110 A=0;
  - expected sequence: `rsp_id` 0,1,0,1; `rsp_y` 7, FFFF_FFFF, 7, FFFF_FFFF; both counters 2.
- Backpressure: FULL with rsp_ready=0 for 3 cycles → both readies 0, `rsp_y`/`rsp_id` stable. Raise rsp_ready with req1 valid (op=011, A=F0F0_F0F0, B=FF00_FF00) → drain and accept in the same cycle, next `rsp_y`=F000_F000.
- All opcodes from req1 with A=8, B=3 → 8, 11, 5, 0, 11, 9, 7, 3.
- Counter wrap with CNT_W=4: 17 accepts by req0 → `grant_cnt0`=1.
- Assert `rst` while FULL and while req0 is valid → `rsp_valid` drops immediately (async), counters 0, and no accept occurs while rst is high.
